idex_stage: RTL

ID/EX pipeline register for the semiMIPS 5-stage core, with integrated load-use hazard detection and branch flush. It captures decoded register numbers, operands, immediate and control bits at the ID/EX boundary. It feeds the forwarding unit (idexrs, idexrt, idexmemwr) and the EX stage. It also produces the PC / IF-ID write enables that stall the front end.

---
 rtl/idex_stage.sv | 102 ++++++++++
 1 files changed

// File: rtl/idex_stage.sv
// ID/EX pipeline register for the semiMIPS core with load-use stall detection,
// branch squash and a saturating stall-event counter.
module idex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          exbranchtaken,
  input  logic [4:0]    ifidrs,
  input  logic [4:0]    ifidrt,
  input  logic [4:0]    ifidrd,
  input  logic          ifidusesrt,
  input  logic [DW-1:0] idreaddata1,
  input  logic [DW-1:0] idreaddata2,
  input  logic [DW-1:0] idimm,
  input  logic [8:0]    idctrl,
  output logic [4:0]    idexrs,
  output logic [4:0]    idexrt,
  output logic [4:0]    idexrd,
  output logic [DW-1:0] idexdata1,
  output logic [DW-1:0] idexdata2,
  output logic [DW-1:0] ideximm,
  output logic [8:0]    idexctrl,
  output logic          idexregwr,
  output logic          idexmemwr,
  output logic          idexvalid,
  output logic          pcwr,
  output logic          ifidwr,
  output logic [CW-1:0] stallcnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [4:0]    rs_reg, rt_reg, rd_reg;
  logic [DW-1:0] data1_reg, data2_reg, imm_reg;
  logic [8:0]    ctrl_reg;
  logic          valid_reg;
  logic [CW-1:0] cnt_reg;
  logic          loaduse;
  logic          bubble;

  // A load in EX whose destination is a source of the ID instruction; $0 never stalls.
  assign loaduse = ctrl_reg[6] && valid_reg && (rt_reg != 5'd0) &&
                   ((rt_reg == ifidrs) || (ifidusesrt && (rt_reg == ifidrt)));
  assign bubble  = exbranchtaken || loaduse;

  assign pcwr   = !hold && (exbranchtaken || !loaduse);
  assign ifidwr = !hold && (exbranchtaken || !loaduse);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_reg    <= '0;
      rt_reg    <= '0;
      rd_reg    <= '0;
      data1_reg <= '0;
      data2_reg <= '0;
      imm_reg   <= '0;
      ctrl_reg  <= '0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (!hold) begin
      if (bubble) begin
        // Zeroed register numbers keep the forwarding unit from matching a bubble.
        rs_reg    <= '0;
        rt_reg    <= '0;
        rd_reg    <= '0;
        data1_reg <= '0;
        data2_reg <= '0;
        imm_reg   <= '0;
        ctrl_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        rs_reg    <= ifidrs;
        rt_reg    <= ifidrt;
        rd_reg    <= ifidrd;
        data1_reg <= idreaddata1;
        data2_reg <= idreaddata2;
        imm_reg   <= idimm;
        ctrl_reg  <= idctrl;
        valid_reg <= 1'b1;
      end
      // Squashed instructions are not counted as stalls.
      if (!exbranchtaken && loaduse && (cnt_reg != CNT_MAX))
        cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign idexrs    = rs_reg;
  assign idexrt    = rt_reg;
  assign idexrd    = rd_reg;
  assign idexdata1 = data1_reg;
  assign idexdata2 = data2_reg;
  assign ideximm   = imm_reg;
  assign idexctrl  = ctrl_reg;
  assign idexregwr = ctrl_reg[8];
  assign idexmemwr = ctrl_reg[7];
  assign idexvalid = valid_reg;
  assign stallcnt  = cnt_reg;

endmodule
